// File: rtl/forward_scoreboard.sv
// In-flight result tracker: forwards youngest matching result, stalls late-result hazards, writes back from oldest slot.
// Latency: forwarded operands registered one cycle after accept, writeback DEPTH cycles after accept; optional FWD_PERF_CNT_EN counters.
// Backpressure: combinational stall holds ID while a matching late result is still below LATE_SLOT; flush overrides stall.
module forward_scoreboard #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int DEPTH     = 3,
  parameter int LATE_SLOT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            iss_valid,
  input  logic            iss_rs1_en,
  input  logic            iss_rs2_en,
  input  logic [RA_W-1:0] iss_rs1_addr,
  input  logic [RA_W-1:0] iss_rs2_addr,
  input  logic            iss_rd_en,
  input  logic [RA_W-1:0] iss_rd_addr,
  input  logic            iss_late,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_data,
  input  logic [XLEN-1:0] late_data,
  output logic            stall,
  output logic            fwd_rs1_hit,
  output logic            fwd_rs2_hit,
  output logic [XLEN-1:0] fwd_rs1_data,
  output logic [XLEN-1:0] fwd_rs2_data,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_addr,
  output logic [XLEN-1:0] wb_data
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] fwd_cnt
`endif
);

  typedef struct packed {
    logic            valid;
    logic            rd_en;
    logic [RA_W-1:0] rd;
    logic            late;
    logic            rdy;
    logic [XLEN-1:0] data;
  } slot_t;

  slot_t           slot_q  [DEPTH];
  slot_t           slot_in [DEPTH];
  logic            now_rdy [DEPTH];
  logic [XLEN-1:0] now_dat [DEPTH];

  logic            rs_en   [2];
  logic [RA_W-1:0] rs_addr [2];
  logic            rs_hit  [2];
  logic            rs_rdy  [2];
  logic [XLEN-1:0] rs_dat  [2];
  logic            accept;

  assign rs_en[0]   = iss_rs1_en;
  assign rs_en[1]   = iss_rs2_en;
  assign rs_addr[0] = iss_rs1_addr;
  assign rs_addr[1] = iss_rs2_addr;

  // Value each slot holds this cycle, including results arriving on ex_data/late_data right now
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      now_rdy[i] = slot_q[i].rdy;
      now_dat[i] = slot_q[i].data;
      if (slot_q[i].valid && !slot_q[i].rdy) begin
        if (i == 0 && !slot_q[i].late) begin
          now_rdy[i] = 1'b1;
          now_dat[i] = ex_data;
        end else if (i == LATE_SLOT && slot_q[i].late) begin
          now_rdy[i] = 1'b1;
          now_dat[i] = late_data;
        end
      end
    end
  end

  // Scan oldest to youngest so the lowest matching index overrides
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rs_hit[k] = 1'b0;
      rs_rdy[k] = 1'b1;
      rs_dat[k] = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (slot_q[i].valid && slot_q[i].rd_en && slot_q[i].rd == rs_addr[k] &&
            rs_addr[k] != '0 && rs_en[k]) begin
          rs_hit[k] = 1'b1;
          rs_rdy[k] = now_rdy[i];
          rs_dat[k] = now_dat[i];
        end
      end
    end
  end

  assign stall  = iss_valid && !flush && !(rs_rdy[0] && rs_rdy[1]);
  assign accept = iss_valid && !flush && !stall;

  always_comb begin
    slot_in[0] = '0;
    if (accept) begin
      slot_in[0].valid = 1'b1;
      slot_in[0].rd_en = iss_rd_en;
      slot_in[0].rd    = iss_rd_addr;
      slot_in[0].late  = iss_late;
    end
    for (int i = 1; i < DEPTH; i++) begin
      slot_in[i]      = slot_q[i-1];
      slot_in[i].rdy  = now_rdy[i-1];
      slot_in[i].data = now_dat[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      fwd_rs1_hit  <= 1'b0;
      fwd_rs2_hit  <= 1'b0;
      fwd_rs1_data <= '0;
      fwd_rs2_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_in[i];
      fwd_rs1_hit  <= accept && rs_hit[0];
      fwd_rs2_hit  <= accept && rs_hit[1];
      fwd_rs1_data <= accept ? rs_dat[0] : '0;
      fwd_rs2_data <= accept ? rs_dat[1] : '0;
    end
  end

  assign wb_en   = slot_q[DEPTH-1].valid && slot_q[DEPTH-1].rd_en && slot_q[DEPTH-1].rd != '0;
  assign wb_addr = wb_en ? slot_q[DEPTH-1].rd : '0;
  assign wb_data = wb_en ? now_dat[DEPTH-1] : '0;

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (accept && (rs_hit[0] || rs_hit[1]) && fwd_cnt != '1) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard at default parameters (DEPTH=3, LATE_SLOT=1).
module tb_forward_scoreboard;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            iss_valid, iss_rs1_en, iss_rs2_en, iss_rd_en, iss_late, flush;
  logic [RA_W-1:0] iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
  logic [XLEN-1:0] ex_data, late_data;
  logic            stall, fwd_rs1_hit, fwd_rs2_hit, wb_en;
  logic [XLEN-1:0] fwd_rs1_data, fwd_rs2_data, wb_data;
  logic [RA_W-1:0] wb_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  forward_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
    .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
    .iss_rd_en(iss_rd_en), .iss_rd_addr(iss_rd_addr), .iss_late(iss_late),
    .flush(flush), .ex_data(ex_data), .late_data(late_data),
    .stall(stall), .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    iss_valid    = 1'b0;
    iss_rs1_en   = 1'b0;
    iss_rs2_en   = 1'b0;
    iss_rs1_addr = '0;
    iss_rs2_addr = '0;
    iss_rd_en    = 1'b0;
    iss_rd_addr  = '0;
    iss_late     = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic issue(input logic r1e, input logic [RA_W-1:0] r1,
                       input logic r2e, input logic [RA_W-1:0] r2,
                       input logic rde, input logic [RA_W-1:0] rd, input logic lt);
    iss_valid    = 1'b1;
    iss_rs1_en   = r1e;
    iss_rs1_addr = r1;
    iss_rs2_en   = r2e;
    iss_rs2_addr = r2;
    iss_rd_en    = rde;
    iss_rd_addr  = rd;
    iss_late     = lt;
    flush        = 1'b0;
  endtask

  task automatic drain;
    idle();
    ex_data   = '0;
    late_data = '0;
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x1 expected 0x0");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    idle();
    ex_data   = '0;
    late_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_hit1", fwd_rs1_hit, 0);
    check("rst_hit2", fwd_rs2_hit, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Three writers in flight, then asynchronous reset mid-cycle
    issue(0, 0, 0, 0, 1, 5'd1, 0); tick();
    ex_data = 32'h1; issue(0, 0, 0, 0, 1, 5'd2, 0); tick();
    ex_data = 32'h2; issue(0, 0, 0, 0, 1, 5'd4, 0); tick();
    ex_data = 32'h4; idle();
    #1;
    check("pre_rst_wb_en", wb_en, 1);
    check("pre_rst_wb_addr", wb_addr, 1);
    check("pre_rst_wb_data", wb_data, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_wb_addr", wb_addr, 0);
    check("mid_rst_wb_data", wb_data, 0);
    check("mid_rst_stall", stall, 0);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_no_wb", wb_en, 0);
    end
    drain();

    // addi x5 then add x6,x5,x5: zero-stall forward from slot 0
    issue(0, 0, 0, 0, 1, 5'd5, 0); tick();
    ex_data = 32'h10; issue(1, 5'd5, 1, 5'd5, 1, 5'd6, 0);
    #1;
    check("ex_fwd_stall", stall, 0);
    tick();
    check("ex_fwd_hit1", fwd_rs1_hit, 1);
    check("ex_fwd_hit2", fwd_rs2_hit, 1);
    check("ex_fwd_data1", fwd_rs1_data, 32'h10);
    check("ex_fwd_data2", fwd_rs2_data, 32'h10);
    idle(); ex_data = 32'h66;
    tick();
    check("x5_wb_en", wb_en, 1);
    check("x5_wb_addr", wb_addr, 5);
    check("x5_wb_data", wb_data, 32'h10);
    drain();

    // Load x7 then use x7: one stall cycle, then late_data forwarded
    issue(0, 0, 0, 0, 1, 5'd7, 1); tick();
    issue(1, 5'd7, 0, 0, 1, 5'd8, 0);
    #1;
    check("lu_stall_c1", stall, 1);
    tick();
    check("lu_bubble_hit", fwd_rs1_hit, 0);
    late_data = 32'hCAFE;
    #1;
    check("lu_stall_c2", stall, 0);
    tick();
    check("lu_hit1", fwd_rs1_hit, 1);
    check("lu_data1", fwd_rs1_data, 32'hCAFE);
    check("lu_hit2", fwd_rs2_hit, 0);
    idle(); late_data = '0;
    drain();

    // Two writers of x3 back-to-back: youngest value forwarded
    issue(0, 0, 0, 0, 1, 5'd3, 0); tick();
    ex_data = 32'h1; issue(0, 0, 0, 0, 1, 5'd3, 0); tick();
    ex_data = 32'h2; issue(1, 5'd3, 1, 5'd3, 0, 0, 0);
    #1;
    check("yng_stall", stall, 0);
    tick();
    check("yng_data1", fwd_rs1_data, 32'h2);
    check("yng_data2", fwd_rs2_data, 32'h2);
    drain();

    // Reader of x9 in the cycle its writer retires
    issue(0, 0, 0, 0, 1, 5'd9, 0); tick();
    idle(); ex_data = 32'h55; tick();
    ex_data = '0; tick();
    issue(1, 5'd9, 0, 0, 0, 0, 0);
    #1;
    check("ret_wb_en", wb_en, 1);
    check("ret_wb_addr", wb_addr, 9);
    check("ret_wb_data", wb_data, 32'h55);
    check("ret_stall", stall, 0);
    tick();
    check("ret_hit1", fwd_rs1_hit, 1);
    check("ret_data1", fwd_rs1_data, 32'h55);
    drain();

    // Flush beats stall: stalling consumer is dropped, a bubble enters slot 0
    issue(0, 0, 0, 0, 1, 5'd10, 1); tick();
    issue(1, 5'd10, 0, 0, 1, 5'd11, 0); flush = 1'b1;
    #1;
    check("fl_stall", stall, 0);
    tick();
    idle();
    check("fl_hit1", fwd_rs1_hit, 0);
    late_data = 32'hBEEF;
    tick();
    late_data = '0;
    check("fl_ld_wb_addr", wb_addr, 10);
    check("fl_ld_wb_data", wb_data, 32'hBEEF);
    tick();
    check("fl_bubble_wb_en", wb_en, 0);
    drain();

    // x0 writer: never forwarded, never written back
    issue(0, 0, 0, 0, 1, 5'd0, 0); tick();
    ex_data = 32'h77; issue(1, 5'd0, 1, 5'd0, 0, 0, 0);
    #1;
    check("x0_stall", stall, 0);
    tick();
    check("x0_hit1", fwd_rs1_hit, 0);
    check("x0_hit2", fwd_rs2_hit, 0);
    check("x0_data1", fwd_rs1_data, 0);
    idle(); ex_data = '0;
    tick();
    check("x0_wb_en", wb_en, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
